// File: rtl/ysyx_24110015_clint_if.sv
// AXI-lite bus bundle between the crossbar CLINT port and the CLINT slave.
// The master modport is the crossbar side. The slave modport is the CLINT side.
// Channels:
//   AR: araddr/arvalid/arready
//   R : rdata/rresp/rvalid/rready
//   AW: awaddr/awvalid/awready
//   W : wdata/wstrb/wvalid/wready
//   B : bresp/bvalid/bready
interface ysyx_24110015_clint_if;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

  modport slave (
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/ysyx_24110015_clint.sv
// CLINT timer: an AXI-lite slave holding a free-running 64-bit mtime.
// Register map:
//   BASE   : mtime[31:0]
//   BASE+4 : mtime[63:32]
// Both words are readable and byte-writable. Any other address returns DECERR.
// mtime advances once every PRESCALE clk cycles.
// Ports:
//   clk - clock
//   rst - asynchronous reset, active high
//   bus - AXI-lite slave (see ysyx_24110015_clint_if)
module ysyx_24110015_clint #(
  parameter logic [31:0] BASE     = 32'h0200_0000,
  parameter int          PRESCALE = 1,
  parameter int          PRESC_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  ysyx_24110015_clint_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, RD_RESP, WR_RESP} state_t;

  localparam logic [1:0]         RESP_OKAY   = 2'b00;
  localparam logic [1:0]         RESP_DECERR = 2'b11;
  localparam logic [PRESC_W-1:0] PRESC_MAX   = PRESC_W'(PRESCALE - 1);

  state_t             state;
  logic [63:0]        mtime;
  logic [PRESC_W-1:0] presc;
  logic [31:0]        rdata_q;
  logic [1:0]         rresp_q, bresp_q;
  logic               rvalid_q, bvalid_q;

  logic [31:0] rd_off, wr_off, rd_word;
  logic        tick, rd_fire, wr_fire, wr_lo, wr_hi, rd_hit;

  // Decode on the full address, so unaligned offsets fall through to DECERR.
  assign rd_off = bus.araddr - BASE;
  assign wr_off = bus.awaddr - BASE;

  // The crossbar holds arvalid/awvalid for a single cycle only,
  // so the readies are combinational.
  // A read wins over a simultaneous write.
  assign bus.arready = (state == IDLE);
  assign bus.awready = (state == IDLE) & bus.awvalid & bus.wvalid & ~bus.arvalid;
  assign bus.wready  = bus.awready;

  assign rd_fire = bus.arvalid & bus.arready;
  assign wr_fire = bus.awready;
  assign wr_lo   = wr_fire & (wr_off == 32'd0);
  assign wr_hi   = wr_fire & (wr_off == 32'd4);
  assign rd_hit  = (rd_off == 32'd0) | (rd_off == 32'd4);
  assign rd_word = (rd_off == 32'd0) ? mtime[31:0] :
                   (rd_off == 32'd4) ? mtime[63:32] : 32'd0;

  assign tick = (presc == PRESC_MAX);

  assign bus.rdata  = rdata_q;
  assign bus.rresp  = rresp_q;
  assign bus.rvalid = rvalid_q;
  assign bus.bresp  = bresp_q;
  assign bus.bvalid = bvalid_q;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++)
      if (strb[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  // Prescaler and mtime.
  // A write to either word pre-empts that cycle's increment.
  // The increment is not applied to either word, so no carry reaches the
  // word that was not written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
      mtime <= 64'd0;
    end else begin
      presc <= tick ? '0 : presc + PRESC_W'(1);
      if (wr_lo)      mtime[31:0]  <= merge(mtime[31:0],  bus.wdata, bus.wstrb);
      else if (wr_hi) mtime[63:32] <= merge(mtime[63:32], bus.wdata, bus.wstrb);
      else if (tick)  mtime        <= mtime + 64'd1;
    end
  end

  // Bus FSM with registered response channels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rdata_q  <= 32'd0;
      rresp_q  <= RESP_OKAY;
      rvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
      bvalid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (rd_fire) begin
            rdata_q  <= rd_word;
            rresp_q  <= rd_hit ? RESP_OKAY : RESP_DECERR;
            rvalid_q <= 1'b1;
            state    <= RD_RESP;
          end else if (wr_fire) begin
            bresp_q  <= (wr_lo | wr_hi) ? RESP_OKAY : RESP_DECERR;
            bvalid_q <= 1'b1;
            state    <= WR_RESP;
          end
        end
        RD_RESP: if (bus.rready) begin
          rvalid_q <= 1'b0;
          state    <= IDLE;
        end
        WR_RESP: if (bus.bready) begin
          bvalid_q <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ysyx_24110015_clint.sv
module tb_ysyx_24110015_clint;
  localparam logic [31:0] BASE = 32'h0200_0000;
  localparam int          P    = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ysyx_24110015_clint_if bus ();
  ysyx_24110015_clint #(.BASE(BASE), .PRESCALE(P), .PRESC_W(16)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: mtime is a 64-bit number.
  // It steps by one each time a P-cycle period elapses.
  // An accepted write to either word replaces that step for its cycle.
  logic [63:0] ref_mt;
  int          ref_ps;
  logic        m_wr = 1'b0;
  logic [31:0] m_addr = 32'd0, m_data = 32'd0;
  logic [3:0]  m_strb = 4'd0;

  function automatic logic [31:0] mrg(input logic [31:0] o, input logic [31:0] d,
                                      input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_mt <= 64'd0;
      ref_ps <= 0;
    end else begin
      ref_ps <= (ref_ps + 1) % P;
      if (m_wr && (m_addr - BASE) == 32'd0)
        ref_mt[31:0] <= mrg(ref_mt[31:0], m_data, m_strb);
      else if (m_wr && (m_addr - BASE) == 32'd4)
        ref_mt[63:32] <= mrg(ref_mt[63:32], m_data, m_strb);
      else if (ref_ps == P - 1)
        ref_mt <= ref_mt + 64'd1;
    end
  end

  function automatic logic [33:0] exp_rd(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    if (off == 32'd0) return {2'b00, ref_mt[31:0]};
    if (off == 32'd4) return {2'b00, ref_mt[63:32]};
    return {2'b11, 32'd0};
  endfunction

  task automatic chk(input string tag, input string fld, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s.%s observed=%h expected=%h", tag, fld, obs, exp);
    end
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input int hold,
                    output logic [31:0] got);
    logic [31:0] ed;
    logic [1:0]  er;
    @(negedge clk);
    chk(tag, "arready_idle", bus.arready, 1);
    {er, ed} = exp_rd(a);
    bus.araddr  = a;
    bus.arvalid = 1'b1;
    @(negedge clk);
    bus.arvalid = 1'b0;
    got = bus.rdata;
    chk(tag, "rvalid", bus.rvalid, 1);
    chk(tag, "rdata", bus.rdata, ed);
    chk(tag, "rresp", bus.rresp, er);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk(tag, "hold_rvalid", bus.rvalid, 1);
      chk(tag, "hold_rdata", bus.rdata, ed);
      chk(tag, "hold_arready", bus.arready, 0);
    end
    bus.rready = 1'b1;
    @(negedge clk);
    bus.rready = 1'b0;
    chk(tag, "rvalid_done", bus.rvalid, 0);
    chk(tag, "arready_done", bus.arready, 1);
  endtask

  task automatic wr(input string tag, input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] s);
    logic [31:0] off;
    off = a - BASE;
    @(negedge clk);
    bus.awaddr = a; bus.wdata = d; bus.wstrb = s;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    #1;
    chk(tag, "awready", bus.awready, 1);
    chk(tag, "wready", bus.wready, 1);
    m_wr = 1'b1; m_addr = a; m_data = d; m_strb = s;
    @(negedge clk);
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; m_wr = 1'b0;
    chk(tag, "bvalid", bus.bvalid, 1);
    chk(tag, "bresp", bus.bresp, (off == 32'd0 || off == 32'd4) ? 2'b00 : 2'b11);
    chk(tag, "awready_busy", bus.awready, 0);
    bus.bready = 1'b1;
    @(negedge clk);
    bus.bready = 1'b0;
    chk(tag, "bvalid_done", bus.bvalid, 0);
  endtask

  logic [31:0] v0, v1;
  logic [31:0] ed;
  logic [1:0]  er;
  logic [31:0] addrs [5];

  initial begin
    bus.araddr = 0; bus.arvalid = 0; bus.rready = 0;
    bus.awaddr = 0; bus.awvalid = 0; bus.wdata = 0; bus.wstrb = 0;
    bus.wvalid = 0; bus.bready = 0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset", "rvalid", bus.rvalid, 0);
    chk("reset", "bvalid", bus.bvalid, 0);
    chk("reset", "rdata", bus.rdata, 0);
    chk("reset", "rresp", bus.rresp, 0);
    chk("reset", "bresp", bus.bresp, 0);
    rst = 1'b0;

    // Idle, then consecutive reads
    repeat (10) @(negedge clk);
    rd("idle_lo", BASE, 0, v0);
    rd("idle_lo2", BASE, 0, v1);
    chk("monotonic", "ge", v1 >= v0, 1);

    // Low-to-high carry
    wr("wr_hi1", BASE + 4, 32'h1, 4'hF);
    wr("wr_lo_fe", BASE, 32'hFFFF_FFFE, 4'hF);
    repeat (6) @(negedge clk);
    rd("carry_hi", BASE + 4, 0, v0);
    rd("carry_lo", BASE, 0, v0);

    // Back-pressured read
    rd("rready_low", BASE, 5, v0);

    // Read and write presented together
    @(negedge clk);
    {er, ed} = exp_rd(BASE + 4);
    bus.araddr = BASE + 4; bus.arvalid = 1'b1;
    bus.awaddr = BASE; bus.wdata = 32'h55; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    #1;
    chk("collide", "arready", bus.arready, 1);
    chk("collide", "awready", bus.awready, 0);
    chk("collide", "wready", bus.wready, 0);
    @(negedge clk);
    bus.arvalid = 1'b0; bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    chk("collide", "rvalid", bus.rvalid, 1);
    chk("collide", "rdata", bus.rdata, ed);
    chk("collide", "bvalid", bus.bvalid, 0);
    bus.rready = 1'b1;
    @(negedge clk);
    bus.rready = 1'b0;
    wr("collide_wr", BASE, 32'h55, 4'hF);

    // Byte strobes
    wr("strb_full", BASE, 32'h1234_5678, 4'hF);
    wr("strb_b1", BASE, 32'h0000_AB00, 4'b0010);
    rd("strb_rd", BASE, 0, v0);

    // Full 64-bit wrap
    wr("wrap_hi", BASE + 4, 32'hFFFF_FFFF, 4'hF);
    wr("wrap_lo", BASE, 32'hFFFF_FFFF, 4'hF);
    repeat (4) @(negedge clk);
    rd("wrap_hi_rd", BASE + 4, 0, v0);
    rd("wrap_lo_rd", BASE, 0, v0);

    // Decode errors
    rd("bad_rd8", 32'h0200_0008, 0, v0);
    rd("bad_rd1", BASE + 1, 0, v0);
    wr("bad_wr3", 32'h0200_0003, 32'hDEAD_BEEF, 4'hF);
    rd("after_bad", BASE, 0, v0);

    // Reset while a read response is outstanding
    @(negedge clk);
    bus.araddr = BASE; bus.arvalid = 1'b1;
    @(negedge clk);
    bus.arvalid = 1'b0;
    chk("rst_mid", "rvalid_pre", bus.rvalid, 1);
    rst = 1'b1;
    #1;
    chk("rst_mid", "rvalid", bus.rvalid, 0);
    chk("rst_mid", "arready", bus.arready, 1);
    @(negedge clk);
    rst = 1'b0;
    rd("rst_mid_rd", BASE, 0, v0);
    rd("rst_mid_rdhi", BASE + 4, 0, v0);

    // Random traffic
    addrs[0] = BASE; addrs[1] = BASE + 4; addrs[2] = BASE + 8;
    addrs[3] = BASE + 2; addrs[4] = $urandom;
    for (int n = 0; n < 40; n++) begin
      int op;
      logic [31:0] a;
      op = $urandom_range(0, 1);
      a = addrs[$urandom_range(0, 4)];
      if (op == 0) rd("rand_rd", a, $urandom_range(0, 2), v0);
      else         wr("rand_wr", a, $urandom, 4'($urandom_range(0, 15)));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
